// File: rtl/alu_pipe_pkg.sv
// Shared decode types for the ALU pipeline: operation and A-shift selects,
// plus the packed flag bundle carried alongside each result.
package Decoders;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } OP_t;

  typedef enum logic [1:0] {
    No_Shift    = 2'b00,
    Shift_Right = 2'b01,
    Shift_Left  = 2'b10,
    Sh_Reserved = 2'b11
  } SH_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '{carry: 1'b0, zero: 1'b0, ovf: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Stateless datapath: pre-shift of operand A (feeds stage 1) and the
// ADD/SUB/AND/OR unit with flag generation (feeds stage 2).
module alu_core
  import Decoders::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  SH_t              sh_i,
  output logic [WIDTH-1:0] a_sh_o,
  output logic             sh_rsvd_o,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  OP_t              op_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;

  // Reserved shift code falls through to the pass-through default.
  always_comb begin
    a_sh_o    = a_i;
    sh_rsvd_o = (sh_i == Sh_Reserved);
    case (sh_i)
      Shift_Right: a_sh_o = {1'b0, a_i[WIDTH-1:1]};
      Shift_Left:  a_sh_o = {a_i[WIDTH-2:0], 1'b0};
      default:     a_sh_o = a_i;
    endcase
  end

  assign sum  = {1'b0, x_i} + {1'b0, y_i};
  assign diff = {1'b0, x_i} - {1'b0, y_i};

  // The extra MSB of diff is the unsigned borrow (x < y).
  always_comb begin
    res           = '0;
    flags_o       = FLAGS_CLEAR;
    case (op_i)
      OP_ADD: begin
        res           = sum[WIDTH-1:0];
        flags_o.carry = sum[WIDTH];
        flags_o.ovf   = (x_i[WIDTH-1] == y_i[WIDTH-1]) &&
                        (sum[WIDTH-1] != x_i[WIDTH-1]);
      end
      OP_SUB: begin
        res           = diff[WIDTH-1:0];
        flags_o.carry = diff[WIDTH];
        flags_o.ovf   = (x_i[WIDTH-1] != y_i[WIDTH-1]) &&
                        (diff[WIDTH-1] != x_i[WIDTH-1]);
      end
      OP_AND:  res = x_i & y_i;
      OP_OR:   res = x_i | y_i;
      default: res = '0;
    endcase
    flags_o.zero = (res == '0);
    result_o     = res;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready on both sides: stage 1 holds the
// shifted A, B and op; stage 2 holds the result and flags until taken.
module alu_pipe
  import Decoders::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic [1:0]       sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             sh_err,
  output logic [15:0]      op_count
);

  // Handshake: a beat moves on either side exactly when valid && ready in
  // the same cycle; valid never depends on ready, and in_ready depends only
  // on registered state and out_ready, never on in_valid.

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  OP_t              s1_op_q, s1_op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic             sh_err_q, sh_err_d;
  logic [15:0]      op_count_q, op_count_d;

  logic [WIDTH-1:0] a_sh;
  logic             sh_rsvd;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  logic in_fire;
  logic out_fire;
  logic s2_load;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i       (a),
    .sh_i      (SH_t'(sh)),
    .a_sh_o    (a_sh),
    .sh_rsvd_o (sh_rsvd),
    .x_i       (s1_a_q),
    .y_i       (s1_b_q),
    .op_i      (s1_op_q),
    .result_o  (alu_res),
    .flags_o   (alu_flags)
  );

  // S2 may refill in the same cycle it hands its result downstream.
  assign out_fire = s2_valid_q && out_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    sh_err_d   = in_fire && sh_rsvd;
    op_count_d = op_count_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_sh;
      s1_b_d     = b;
      s1_op_d    = OP_t'(op);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = alu_res;
      flags_d    = alu_flags;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (out_fire) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= FLAGS_CLEAR;
      sh_err_q   <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      sh_err_q   <= sh_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign ovf       = flags_q.ovf;
  assign sh_err    = sh_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, randomized traffic against an
// arithmetic reference model, backpressure and mid-flight reset sequences.
module tb_alu_pipe;
  import Decoders::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic [1:0]   sh = 2'b00;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         ovf;
  logic         sh_err;
  logic [15:0]  op_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are packed {carry, zero, ovf, result}.
  logic [W+2:0] exp_q[$];
  int           m_count = 0;
  int           acc_cnt = 0;
  logic         exp_sh = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W+2:0] prev_data = '0;
  logic         mon_en = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [1:0]   sh;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
  } vec_t;

  vec_t vecs[9];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .sh        (sh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
    .sh_err    (sh_err),
    .op_count  (op_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+2:0] ref_model(input int av, input int bv, input int opv, input int shv);
    int md, half, ap, r, sa, sb, s;
    logic c, o;
    logic [W+2:0] ret;
    md = 1 << W;
    half = md / 2;
    if (shv == 1) ap = av / 2;
    else if (shv == 2) ap = (av * 2) % md;
    else ap = av;
    sa = (ap >= half) ? ap - md : ap;
    sb = (bv >= half) ? bv - md : bv;
    c = 1'b0;
    o = 1'b0;
    case (opv)
      0: begin r = (ap + bv) % md; c = (ap + bv) >= md; s = sa + sb; o = (s < -half) || (s >= half); end
      1: begin r = (ap - bv + md) % md; c = ap < bv; s = sa - sb; o = (s < -half) || (s >= half); end
      2: r = ap & bv;
      default: r = ap | bv;
    endcase
    ret = {c, (r == 0), o, r[W-1:0]};
    return ret;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {21'd0, carry, zero, ovf, result}, {21'd0, prev_data});
      end
      check("sh_err", {31'd0, sh_err}, {31'd0, exp_sh});
      check("op_count", {16'd0, op_count}, m_count[31:0] & 32'hFFFF);
      if (rst) begin
        exp_q.delete();
        m_count = 0;
        exp_sh = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", {31'd0, out_valid}, 32'd0);
          end else begin
            check("out_data", {21'd0, carry, zero, ovf, result}, {21'd0, exp_q.pop_front()});
          end
          m_count++;
        end
        exp_sh = in_valid && in_ready && (sh == 2'b11);
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_model(int'(a), int'(b), int'(op), int'(sh)));
          acc_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data = {carry, zero, ovf, result};
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [1:0] opv, input logic [1:0] shv);
    logic ok;
    ok = 1'b0;
    a = av; b = bv; op = opv; sh = shv;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic run_vec(input int idx);
    logic got;
    int lat;
    got = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vecs[idx].a, vecs[idx].b, vecs[idx].op, vecs[idx].sh);
    in_valid = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (k == 1) check($sformatf("v%0d_sh_err", idx), {31'd0, sh_err}, {31'd0, vecs[idx].sh == 2'b11});
      if (out_valid) begin
        got = 1'b1;
        lat = k;
        check($sformatf("v%0d_result", idx), {24'd0, result}, {24'd0, vecs[idx].res});
        check($sformatf("v%0d_flags", idx), {29'd0, carry, zero, ovf},
              {29'd0, vecs[idx].c, vecs[idx].z, vecs[idx].o});
      end
    end
    if (!got) check($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
    else check($sformatf("v%0d_latency", idx), lat, 32'd2);
    @(negedge clk);
    check($sformatf("v%0d_sh_err_clear", idx), {31'd0, sh_err}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int acc_base;
    int seen;

    vecs[0] = '{8'h0F, 8'h01, 2'(OP_ADD), 2'(No_Shift),    8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h80, 8'h00, 2'(OP_ADD), 2'(Shift_Left),  8'h00, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 2'(OP_ADD), 2'(No_Shift),    8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h02, 8'h05, 2'(OP_SUB), 2'(Shift_Right), 8'hFC, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hF0, 8'h3C, 2'(OP_AND), 2'(No_Shift),    8'h30, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hF0, 8'h3C, 2'(OP_OR),  2'(No_Shift),    8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h05, 8'h00, 2'(OP_ADD), 2'b11,           8'h05, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'h01, 2'(OP_ADD), 2'(No_Shift),    8'h00, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h01, 2'(OP_SUB), 2'(No_Shift),    8'h7F, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_flags", {29'd0, carry, zero, ovf}, 32'd0);
    check("rst_sh_err", {31'd0, sh_err}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 9; i++) run_vec(i);

    // Randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a  = W'($urandom);
      b  = W'($urandom);
      op = 2'($urandom_range(0, 3));
      sh = 2'($urandom_range(0, 3));
    end
    drain();

    // Ten back-to-back commands against a 5-cycle output stall
    reset_dut();
    @(posedge clk); #1;
    acc_base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(W'(i * 17 + 3), W'(i * 5), 2'(i % 4), 2'(i % 3));
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_accepted", acc_cnt - acc_base, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_op_count", {16'd0, op_count}, 32'd10);
    check("bp_all_taken", acc_cnt - acc_base, 32'd10);

    // Reset with both stages occupied
    reset_dut();
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(8'h11, 8'h22, 2'(OP_ADD), 2'(No_Shift));
    send(8'h33, 8'h44, 2'(OP_SUB), 2'(No_Shift));
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_op_count", {16'd0, op_count}, 32'd0);
    check("midrst_result", {24'd0, result}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_stale", seen, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
